// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one pipelined sprite/background ROM between pixel-fetch requesters.
// Define ARB_BG_PRIORITY_EN to give requester 0 (background fetch) strict priority over the sprites.
module sprite_rom_arbiter #(
  parameter int NREQ    = 3,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 2
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     frame_sync,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]          gnt,
  output logic                     rom_rd,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic [DATA_W-1:0]        rdata,
  output logic [NREQ-1:0]          rvalid,
  output logic                     busy
);

  localparam int              PTR_W  = $clog2(NREQ);
  localparam logic [PTR_W:0]  NREQ_E = (PTR_W+1)'(NREQ);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(NREQ-1);

  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt, win;
  logic             found, ptr_adv;
  logic [PTR_W:0]   cand;
  logic [ROM_LAT:0] tag_v;
  logic [PTR_W-1:0] tag_idx [ROM_LAT+1];

  // Candidate index wraps with an explicit compare so non-power-of-2 NREQ works.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
`ifdef ARB_BG_PRIORITY_EN
    if (req[0]) found = 1'b1;
`endif
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= NREQ_E) cand = cand - NREQ_E;
`ifdef ARB_BG_PRIORITY_EN
      if (!found && (cand != '0) && req[cand[PTR_W-1:0]]) begin
`else
      if (!found && req[cand[PTR_W-1:0]]) begin
`endif
        found = 1'b1;
        win   = cand[PTR_W-1:0];
      end
    end
    if (!Reset_n) found = 1'b0;
  end

  always_comb begin
    gnt = '0;
    if (found) gnt[win] = 1'b1;
  end

`ifdef ARB_BG_PRIORITY_EN
  assign ptr_adv = found && (win != '0);
`else
  assign ptr_adv = found;
`endif

  // frame_sync restart wins over the post-grant advance.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (frame_sync)   rr_ptr_nxt = '0;
    else if (ptr_adv) rr_ptr_nxt = (win == LAST) ? '0 : win + PTR_W'(1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr   <= '0;
      rom_addr <= '0;
      tag_v    <= '0;
      for (int k = 0; k <= ROM_LAT; k++) tag_idx[k] <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
      if (found) rom_addr <= req_addr[win*ADDR_W +: ADDR_W];
      tag_v      <= {tag_v[ROM_LAT-1:0], found};
      tag_idx[0] <= win;
      for (int k = 1; k <= ROM_LAT; k++) tag_idx[k] <= tag_idx[k-1];
    end
  end

  assign rom_rd = tag_v[0];
  assign rdata  = rom_data;
  assign busy   = |tag_v;

  always_comb begin
    rvalid = '0;
    if (tag_v[ROM_LAT]) rvalid[tag_idx[ROM_LAT]] = 1'b1;
  end

endmodule
